// File: rtl/rv_mul_pipe.sv
// Pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with valid/ready flow control and flush.
// Results leave in acceptance order after STAGES cycles, carrying their destination tag.
module rv_mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [TAG_W-1:0] rd_tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_out,
    output logic [TAG_W-1:0] rd_tag_out,
    output logic             illegal_out,
    output logic             busy
);

    localparam int PW = 2 * WIDTH;

    function automatic logic [WIDTH-1:0] select_half(input logic [2:0] f, input logic [PW-1:0] p);
        logic [WIDTH-1:0] r;
        case (f)
            3'b000:                 r = p[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: r = p[PW-1:WIDTH];
            default:                r = '0;
        endcase
        return r;
    endfunction

    logic [STAGES-1:0] valid_r;
    logic [TAG_W-1:0]  tag_r  [STAGES];
    logic [2:0]        func_r [STAGES-1];
    logic [WIDTH:0]    opa_r;
    logic [WIDTH:0]    opb_r;
    logic [WIDTH-1:0]  result_r;
    logic              illegal_r;

    logic              advance;
    logic              sext_a;
    logic              sext_b;
    logic [PW-1:0]     opa_x;
    logic [PW-1:0]     opb_x;
    logic [PW-1:0]     prod_c;
    logic [PW-1:0]     pre_sel;

    assign advance  = !valid_r[STAGES-1] || out_ready;
    assign in_ready = advance && !flush;
    assign sext_a   = (func3 == 3'b001) || (func3 == 3'b010);
    assign sext_b   = (func3 == 3'b001);

    // The low 2*WIDTH bits of the (WIDTH+1)-bit signed product equal those of the
    // same operands sign-extended to 2*WIDTH, which keeps every width exact.
    assign opa_x  = {{(WIDTH-1){opa_r[WIDTH]}}, opa_r};
    assign opb_x  = {{(WIDTH-1){opb_r[WIDTH]}}, opb_r};
    assign prod_c = opa_x * opb_x;

    generate
        if (STAGES == 2) begin : g_short
            assign pre_sel = prod_c;
        end else begin : g_long
            logic [PW-1:0] prod_r [STAGES-2];

            // Product retiming registers between stage 1 and the last stage
            always_ff @(posedge clk) begin
                if (advance) begin
                    prod_r[0] <= prod_c;
                    for (int i = 1; i < STAGES - 2; i++) begin
                        prod_r[i] <= prod_r[i-1];
                    end
                end
            end

            assign pre_sel = prod_r[STAGES-3];
        end
    endgenerate

    // Stage-0 operand capture with per-func3 sign extension
    always_ff @(posedge clk) begin
        if (advance) begin
            opa_r <= {sext_a & rs1[WIDTH-1], rs1};
            opb_r <= {sext_b & rs2[WIDTH-1], rs2};
        end
    end

    // Valid/tag/func shift chain and registered output stage; flush beats out_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= '0;
            result_r  <= '0;
            illegal_r <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                tag_r[i] <= '0;
            end
            for (int i = 0; i < STAGES - 1; i++) begin
                func_r[i] <= 3'b000;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else if (advance) begin
            valid_r   <= {valid_r[STAGES-2:0], in_valid};
            tag_r[0]  <= rd_tag_in;
            func_r[0] <= func3;
            for (int i = 1; i < STAGES; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            for (int i = 1; i < STAGES - 1; i++) begin
                func_r[i] <= func_r[i-1];
            end
            result_r  <= select_half(func_r[STAGES-2], pre_sel);
            illegal_r <= func_r[STAGES-2][2];
        end
    end

    assign out_valid   = valid_r[STAGES-1];
    assign result_out  = result_r;
    assign rd_tag_out  = tag_r[STAGES-1];
    assign illegal_out = illegal_r;
    assign busy        = |valid_r;

endmodule

// File: tb/tb_rv_mul_pipe.sv
// Directed self-checking bench for rv_mul_pipe (WIDTH=32, STAGES=3, TAG_W=5).
module tb_rv_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_tag_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_out;
    logic [4:0]  rd_tag_out;
    logic        illegal_out;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    rv_mul_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .func3(func3), .rs1(rs1), .rs2(rs2), .rd_tag_in(rd_tag_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result_out(result_out), .rd_tag_out(rd_tag_out),
        .illegal_out(illegal_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] er, input logic ei);
        int lat;
        func3 = f; rs1 = a; rs2 = b; rd_tag_in = t; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd3);
        check({name, "_result"}, 64'(result_out), 64'(er));
        check({name, "_tag"}, 64'(rd_tag_out), 64'(t));
        check({name, "_illegal"}, 64'(illegal_out), 64'(ei));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int sent;
        int rcv;
        int cnt;
        logic held;
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        logic accept;

        rst = 1'b1; in_valid = 1'b0; func3 = 3'b000; rs1 = 32'd0; rs2 = 32'd0;
        rd_tag_in = 5'd0; flush = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result_out), 64'd0);
        check("rst_tag", 64'(rd_tag_out), 64'd0);
        check("rst_illegal", 64'(illegal_out), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 1'b0);
        check("mul_7x-3_busy_after", 64'(busy), 64'd0);
        check("mul_7x-3_valid_after", 64'(out_valid), 64'd0);

        run_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b0);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhu_m1", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1'b0);
        run_op("mul_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 1'b0);
        run_op("mul_minneg", 3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b0);
        run_op("mulh_minsq", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 1'b0);
        run_op("mulhsu_min", 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'hC000_0000, 1'b0);
        run_op("mulhu_zero", 3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1'b0);

        // Throughput: op c offered in cycle c, result in cycle c+3
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8); func3 = 3'b000; rs1 = 32'(c); rs2 = 32'(c + 1);
            rd_tag_in = 5'(c); out_ready = 1'b1;
            #1;
            if (c < 8) check("tp_in_ready", 64'(in_ready), 64'd1);
            tick();
            check("tp_out_valid", 64'(out_valid), 64'((c + 1 >= 3) && (c + 1 <= 10)));
            if (out_valid) begin
                check("tp_result", 64'(result_out), 64'((c - 2) * (c - 1)));
                check("tp_tag", 64'(rd_tag_out), 64'(c - 2));
            end
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: out_ready low for cycles 3..6
        sent = 0; rcv = 0; held = 1'b0; held_res = '0; held_tag = '0;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            in_valid = (sent < 6); func3 = 3'b000;
            rs1 = 32'(sent + 10); rs2 = 32'(3 * sent + 1); rd_tag_in = 5'(20 + sent);
            out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            if (held) begin
                check("bp_hold_result", 64'(result_out), 64'(held_res));
                check("bp_hold_tag", 64'(rd_tag_out), 64'(held_tag));
            end
            if (out_valid && !out_ready) check("bp_stall_in_ready", 64'(in_ready), 64'd0);
            accept = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("bp_result", 64'(result_out), 64'((rcv + 10) * (3 * rcv + 1)));
                check("bp_tag", 64'(rd_tag_out), 64'(20 + rcv));
                rcv++;
            end
            held = out_valid && !out_ready;
            held_res = result_out;
            held_tag = rd_tag_out;
            if (accept) sent++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_received", 64'(rcv), 64'd6);
        check("bp_sent", 64'(sent), 64'd6);
        tick();
        check("bp_busy_drained", 64'(busy), 64'd0);

        // Flush with three ops in flight and a fresh op offered
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; func3 = 3'b000; rs1 = 32'(i + 2); rs2 = 32'd3; rd_tag_in = 5'(i + 1);
            tick();
        end
        rd_tag_in = 5'd30; flush = 1'b1; out_ready = 1'b1;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        check("fl_valid_before", 64'(out_valid), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_busy", 64'(busy), 64'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        check("fl_no_output", 64'(cnt), 64'd0);
        run_op("fl_after", 3'b000, 32'd6, 32'd7, 5'd13, 32'd42, 1'b0);

        // Asynchronous reset with a result on the output
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; func3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5; rd_tag_in = 5'(i + 17);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("ar_valid_before", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_result", 64'(result_out), 64'd0);
        check("ar_tag", 64'(rd_tag_out), 64'd0);
        check("ar_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) cnt++;
            tick();
        end
        check("ar_no_stale", 64'(cnt), 64'd0);

        run_op("illegal_100", 3'b100, 32'd5, 32'd6, 5'd4, 32'd0, 1'b1);
        run_op("illegal_111", 3'b111, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 32'd0, 1'b1);
        run_op("legal_after", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd11, 32'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
